inst_fetch_unit: RTL

Instruction-fetch stage of the CPU pipeline. Generates the PC, issues single-word read requests on the sram-like instruction port of the AXI bridge, buffers the returned instruction, and hands it to the decode stage with a valid/allow-in handshake. It also handles branch and exception redirects, including discarding a response that is already in flight. At most one fetch is outstanding at any time.

---
 rtl/inst_fetch_unit_if.sv | 25 ++
 rtl/inst_fetch_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit_if.sv
// Instruction-side sram-like bus between the fetch stage and the AXI bridge.
// Handshake: the fetch stage holds req high with a stable addr until the
// bridge pulses addr_ok (request accepted). data_ok later pulses for exactly
// one cycle with rdata valid. At most one request is outstanding.
interface inst_fetch_unit_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: PC generation, single outstanding word fetch,
// one-entry instruction buffer and branch/exception redirect handling,
// including discarding a response that is already in flight.
// Decode handshake: fs_valid presents fs_pc/fs_inst/fs_adel; the instruction
// is consumed on a rising edge where fs_valid & ds_allow_in are both high.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic                     clk,
  input  logic                     reset,
  inst_fetch_unit_if.master        inst_sram,
  input  logic                     br_taken,
  input  logic [31:0]              br_target,
  input  logic                     ex_flush,
  input  logic [31:0]              ex_target,
  input  logic                     ds_allow_in,
  output logic                     fs_valid,
  output logic [31:0]              fs_pc,
  output logic [31:0]              fs_inst,
  output logic                     fs_adel,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst_buf;
  logic        adel;
  logic        cancel;
  logic [31:0] pend_pc;

  logic        redirect;
  logic [31:0] target;
  logic        pc_aligned;

  // Exception/eret redirect wins over a branch in the same cycle.
  assign redirect   = ex_flush | br_taken;
  assign target     = ex_flush ? ex_target : br_target;
  assign pc_aligned = (pc[1:0] == 2'b00);

  // Bus side: read-only word requests at the current PC.
  assign inst_sram.req   = (state == S_REQ) & pc_aligned;
  assign inst_sram.addr  = pc;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'd2;
  assign inst_sram.wstrb = 4'b0000;
  assign inst_sram.wdata = 32'h0000_0000;

  // Decode side: everything registered except the redirect kill on fs_valid.
  assign fs_valid  = (state == S_HOLD) & ~redirect;
  assign fs_pc     = pc;
  assign fs_inst   = inst_buf;
  assign fs_adel   = adel;
  assign dbg_state = state;

  // Fetch FSM: request, wait for data (or discard it), hold for decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      inst_buf <= 32'h0000_0000;
      adel     <= 1'b0;
      cancel   <= 1'b0;
      pend_pc  <= 32'h0000_0000;
    end else begin
      case (state)
        S_REQ: begin
          if (!pc_aligned) begin
            // Misaligned PC never reaches the bus; a redirect simply retargets.
            if (redirect) begin
              pc <= target;
            end else begin
              adel     <= 1'b1;
              inst_buf <= 32'h0000_0000;
              state    <= S_HOLD;
            end
          end else begin
            // The request must stay stable until accepted, so a redirect is
            // remembered and applied once the response has been drained.
            if (redirect) begin
              cancel  <= 1'b1;
              pend_pc <= target;
            end
            if (inst_sram.addr_ok) begin
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (inst_sram.data_ok) begin
            if (cancel || redirect) begin
              pc     <= redirect ? target : pend_pc;
              cancel <= 1'b0;
              state  <= S_REQ;
            end else begin
              inst_buf <= inst_sram.rdata;
              adel     <= 1'b0;
              state    <= S_HOLD;
            end
          end else if (redirect) begin
            cancel  <= 1'b1;
            pend_pc <= target;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= S_REQ;
          end else if (ds_allow_in) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end

        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule
